// File: rtl/fwd_pkg.sv
// Shared types and defaults for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_REG_AW    = 5;
  localparam int DEF_NUM_SRC   = 2;
  localparam int DEF_NUM_STG   = 3;
  localparam int DEF_STALL_CYC = 1;
  localparam int DEF_CNT_W     = 16;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/fwd_src_mux.sv
// Per-source priority match over the write-back stages; stage 0 (youngest) wins.
module fwd_src_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_STG = DEF_NUM_STG
) (
  input  logic                      src_valid,
  input  logic [REG_AW-1:0]         src_reg,
  input  logic [DATA_W-1:0]         src_val,
  input  logic [NUM_STG-1:0]        stg_we,
  input  logic [NUM_STG*REG_AW-1:0] stg_reg,
  input  logic [NUM_STG*DATA_W-1:0] stg_val,
  input  logic [NUM_STG-1:0]        stg_load,
  output logic [DATA_W-1:0]         val,
  output logic                      hit,
  output logic                      load_pend
);

  logic src_live;

  always_comb begin
    val       = src_val;
    hit       = 1'b0;
    load_pend = 1'b0;
    src_live  = src_valid && (src_reg != REG_AW'(ZERO_REG));
    // Oldest first so younger matches overwrite; the load flag follows the winner,
    // so an older non-load never hides a younger load.
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (src_live && stg_we[k] && (stg_reg[k*REG_AW +: REG_AW] == src_reg)) begin
        val       = stg_val[k*DATA_W +: DATA_W];
        hit       = 1'b1;
        load_pend = stg_load[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall sequencing between ID/EXE and EXE.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int NUM_STG   = DEF_NUM_STG,
  parameter int STALL_CYC = DEF_STALL_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [NUM_SRC-1:0]        src_valid_IN,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg_IN,
  input  logic [NUM_SRC*DATA_W-1:0] src_val_IN,
  input  logic [NUM_STG-1:0]        stg_we_IN,
  input  logic [NUM_STG*REG_AW-1:0] stg_reg_IN,
  input  logic [NUM_STG*DATA_W-1:0] stg_val_IN,
  input  logic [NUM_STG-1:0]        stg_load_IN,
  input  logic                      advance_IN,
  output logic [NUM_SRC*DATA_W-1:0] operand_OUT,
  output logic [NUM_SRC-1:0]        fwd_hit_OUT,
  output logic                      _forward,
  output logic                      stall_OUT
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          fwd_cnt_OUT,
  output logic [CNT_W-1:0]          stall_cnt_OUT
`endif
);

  localparam int BW = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

  logic [NUM_SRC-1:0][DATA_W-1:0] mux_val;
  logic [NUM_SRC-1:0]             mux_hit;
  logic [NUM_SRC-1:0]             mux_ld;
  logic                           hazard;
  logic                           stall;
  logic                           capture;

  fwd_state_e                     state_q, state_d;
  logic [BW-1:0]                  cnt_q, cnt_d;
  logic [NUM_SRC-1:0][DATA_W-1:0] operand_q, operand_d;
  logic [NUM_SRC-1:0]             hit_q, hit_d;
  logic                           fwd_q, fwd_d;

  for (genvar gs = 0; gs < NUM_SRC; gs++) begin : g_src
    fwd_src_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .NUM_STG(NUM_STG)
    ) u_mux (
      .src_valid(src_valid_IN[gs]),
      .src_reg  (src_reg_IN[gs*REG_AW +: REG_AW]),
      .src_val  (src_val_IN[gs*DATA_W +: DATA_W]),
      .stg_we   (stg_we_IN),
      .stg_reg  (stg_reg_IN),
      .stg_val  (stg_val_IN),
      .stg_load (stg_load_IN),
      .val      (mux_val[gs]),
      .hit      (mux_hit[gs]),
      .load_pend(mux_ld[gs])
    );
  end

  assign hazard = |mux_ld;

  // The RUN cycle that detects the hazard is the first bubble; the counter holds the
  // bubbles still owed after it and RUN is re-entered once none remain and the hazard is gone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = hazard;
        if (hazard) begin
          cnt_d = BW'(STALL_CYC - 1);
          if (STALL_CYC > 1) state_d = STALL;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (advance_IN && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
        if ((cnt_d == '0) && !hazard) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_OUT = RESET && stall;
  assign capture   = advance_IN && !stall_OUT;

  always_comb begin
    operand_d = operand_q;
    hit_d     = hit_q;
    fwd_d     = fwd_q;
    if (capture) begin
      operand_d = mux_val;
      hit_d     = mux_hit;
      fwd_d     = |mux_hit;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      operand_q <= '0;
      hit_q     <= '0;
      fwd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      hit_q     <= hit_d;
      fwd_q     <= fwd_d;
    end
  end

  assign operand_OUT = operand_q;
  assign fwd_hit_OUT = hit_q;
  assign _forward    = fwd_q;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W:0]   fwd_sum;

  // One guard bit absorbs the per-capture hit count before saturating.
  always_comb begin
    fwd_sum = {1'b0, fwd_cnt_q};
    if (capture) begin
      for (int s = 0; s < NUM_SRC; s++) fwd_sum = fwd_sum + (CNT_W+1)'(mux_hit[s]);
    end
    fwd_cnt_d   = fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
    stall_cnt_d = stall_cnt_q;
    if (stall_OUT && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt_OUT   = fwd_cnt_q;
  assign stall_cnt_OUT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against a behavioural model.
module tb_fwd_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NK = 3;
  localparam int SC = 2;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0][AW-1:0]  src_reg;
  logic [NS-1:0][DW-1:0]  src_val;
  logic [NK-1:0]          stg_we;
  logic [NK-1:0][AW-1:0]  stg_reg;
  logic [NK-1:0][DW-1:0]  stg_val;
  logic [NK-1:0]          stg_load;
  logic                   adv;
  logic [NS*DW-1:0]       operand;
  logic [NS-1:0]          fwd_hit;
  logic                   fwd;
  logic                   stall;
`ifdef FWD_PERF_CNT_EN
  logic [CW-1:0]          fwd_cnt;
  logic [CW-1:0]          stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [DW-1:0] m_op [NS];
  bit            m_hit[NS];
  bit            m_fwd;
  bit            m_in_stall;
  int            m_left;
  longint        m_fcnt;
  longint        m_scnt;

  fwd_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .NUM_STG(NK), .STALL_CYC(SC), .CNT_W(CW)
  ) dut (
    .CLOCK       (clk),
    .RESET       (rst_n),
    .src_valid_IN(src_valid),
    .src_reg_IN  (src_reg),
    .src_val_IN  (src_val),
    .stg_we_IN   (stg_we),
    .stg_reg_IN  (stg_reg),
    .stg_val_IN  (stg_val),
    .stg_load_IN (stg_load),
    .advance_IN  (adv),
    .operand_OUT (operand),
    .fwd_hit_OUT (fwd_hit),
    ._forward    (fwd),
    .stall_OUT   (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .fwd_cnt_OUT  (fwd_cnt),
    .stall_cnt_OUT(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // First matching stage in age order decides the operand.
  function automatic void resolve(input int s, output logic [DW-1:0] v, output bit h, output bit ld);
    v = src_val[s]; h = 0; ld = 0;
    if (src_valid[s] && src_reg[s] != 0) begin
      for (int k = 0; k < NK; k++) begin
        if (stg_we[k] && stg_reg[k] == src_reg[s]) begin
          v = stg_val[k]; h = 1; ld = stg_load[k];
          break;
        end
      end
    end
  endfunction

  function automatic bit hazard_now();
    logic [DW-1:0] v; bit h, ld;
    bit hz = 0;
    for (int s = 0; s < NS; s++) begin
      resolve(s, v, h, ld);
      if (ld) hz = 1;
    end
    return hz;
  endfunction

  function automatic bit exp_stall();
    return rst_n && (m_in_stall || hazard_now());
  endfunction

  task automatic idle_inputs();
    src_valid = '0; src_reg = '0; src_val = '0;
    stg_we = '0; stg_reg = '0; stg_val = '0; stg_load = '0;
    adv = 1'b1;
  endtask

  // Advance one clock and update the model with the values seen at that edge.
  task automatic tick();
    bit st, hz;
    logic [DW-1:0] rv[NS]; bit rh[NS]; bit rl;
    int nh;
    st = exp_stall();
    hz = hazard_now();
    nh = 0;
    for (int s = 0; s < NS; s++) begin
      resolve(s, rv[s], rh[s], rl);
      nh += int'(rh[s]);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin m_op[s] = '0; m_hit[s] = 0; end
      m_fwd = 0; m_in_stall = 0; m_left = 0; m_fcnt = 0; m_scnt = 0;
    end else begin
      if (adv && !st) begin
        for (int s = 0; s < NS; s++) begin m_op[s] = rv[s]; m_hit[s] = rh[s]; end
        m_fwd = (nh != 0);
        m_fcnt = (m_fcnt + nh > CMAX) ? CMAX : m_fcnt + nh;
      end
      if (st && m_scnt < CMAX) m_scnt++;
      if (!m_in_stall) begin
        if (hz) begin m_left = SC - 1; m_in_stall = (SC > 1); end
      end else begin
        if (adv && m_left > 0) m_left--;
        if (m_left == 0 && !hz) m_in_stall = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    src_valid = 2'b01; src_reg[0] = 5'd4;
    stg_we = 3'b001; stg_reg[0] = 5'd4; stg_load = 3'b001;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    tick(); tick();
    checks++;
    if (operand !== '0) begin errors++; $display("FAIL reset_operand got %h want 0", operand); end
    checks++;
    if (fwd_hit !== '0 || fwd !== 1'b0) begin errors++; $display("FAIL reset_hit got %b/%b want 0/0", fwd_hit, fwd); end
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    src_valid = 2'b01; src_reg[0] = 5'd3; src_val[0] = 32'h1111_1111; src_val[1] = 32'h0000_0022;
    stg_we = 3'b011; stg_reg[0] = 5'd3; stg_reg[1] = 5'd3;
    stg_val[0] = 32'hAAAA_0001; stg_val[1] = 32'hBBBB_0002;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %b want 0", stall); end
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'hAAAA_0001) begin errors++; $display("FAIL prio_op0 got %h want aaaa0001", operand[DW-1:0]); end
    checks++;
    if (fwd_hit !== 2'b01 || fwd !== 1'b1) begin errors++; $display("FAIL prio_hit got %b/%b want 01/1", fwd_hit, fwd); end
    checks++;
    if (operand[2*DW-1:DW] !== 32'h0000_0022) begin errors++; $display("FAIL prio_op1 got %h want 00000022", operand[2*DW-1:DW]); end
    stg_we = 3'b111; stg_reg[2] = 5'd3; stg_val[2] = 32'hCCCC_0003; stg_val[0] = 32'hAAAA_0004;
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'hAAAA_0004) begin errors++; $display("FAIL prio_all3 got %h want aaaa0004", operand[DW-1:0]); end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    src_valid = 2'b10; src_reg[1] = 5'd0; src_val[1] = 32'h1234_5678;
    stg_we = 3'b001; stg_reg[0] = 5'd0; stg_val[0] = 32'h0000_DEAD;
    tick();
    checks++;
    if (operand[2*DW-1:DW] !== 32'h1234_5678) begin errors++; $display("FAIL zero_op1 got %h want 12345678", operand[2*DW-1:DW]); end
    checks++;
    if (fwd_hit !== 2'b00 || fwd !== 1'b0) begin errors++; $display("FAIL zero_hit got %b/%b want 00/0", fwd_hit, fwd); end
  endtask

  task automatic test_we_qualify();
    idle_inputs();
    src_valid = 2'b01; src_reg[0] = 5'd7; src_val[0] = 32'h0000_7777;
    stg_reg[0] = 5'd7; stg_reg[1] = 5'd7; stg_reg[2] = 5'd7; stg_load = 3'b111;
    stg_val[0] = 32'h1; stg_val[1] = 32'h2; stg_val[2] = 32'h3;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL we_stall got %b want 0", stall); end
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'h0000_7777 || fwd_hit[0] !== 1'b0) begin
      errors++; $display("FAIL we_op0 got %h/%b want 00007777/0", operand[DW-1:0], fwd_hit[0]);
    end
  endtask

  task automatic test_load_stall();
    idle_inputs();
    src_valid = 2'b01; src_reg[0] = 5'd5; src_val[0] = 32'h5555_AAAA;
    tick();
    stg_we = 3'b001; stg_reg[0] = 5'd5; stg_val[0] = 32'h0000_0BAD; stg_load = 3'b001;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall1 got %b want 1", stall); end
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'h5555_AAAA) begin errors++; $display("FAIL ld_hold1 got %h want 5555aaaa", operand[DW-1:0]); end
    stg_we = 3'b010; stg_load = 3'b000; stg_reg[1] = 5'd5; stg_val[1] = 32'h0000_F00D;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall2 got %b want 1", stall); end
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'h5555_AAAA) begin errors++; $display("FAIL ld_hold2 got %h want 5555aaaa", operand[DW-1:0]); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ld_stall3 got %b want 0", stall); end
    tick();
    checks++;
    if (operand[DW-1:0] !== 32'h0000_F00D || fwd_hit[0] !== 1'b1) begin
      errors++; $display("FAIL ld_fwd got %h/%b want 0000f00d/1", operand[DW-1:0], fwd_hit[0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    src_valid = 2'b11; src_reg[0] = 5'd6; src_val[0] = 32'h6666_0000; src_val[1] = 32'h0000_9999;
    tick();
    stg_we = 3'b001; stg_reg[0] = 5'd6; stg_load = 3'b001;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
    tick();
    checks++;
    if (operand !== '0 || fwd_hit !== '0 || fwd !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out got %h/%b/%b want 0/0/0", operand, fwd_hit, fwd);
    end
    rst_n = 1'b1;
    stg_we = '0; stg_load = '0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_run got %b want 0", stall); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      adv = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = ($urandom_range(0, 5) != 0);
        src_reg[s] = AW'($urandom_range(0, 3));
        src_val[s] = $urandom;
      end
      for (int k = 0; k < NK; k++) begin
        stg_we[k] = $urandom_range(0, 1);
        stg_reg[k] = AW'($urandom_range(0, 3));
        stg_val[k] = $urandom;
        stg_load[k] = ($urandom_range(0, 5) == 0);
      end
      #1;
      checks++;
      if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall i=%0d got %b want %b", i, stall, exp_stall()); end
      tick();
      for (int s = 0; s < NS; s++) begin
        checks++;
        if (operand[s*DW +: DW] !== m_op[s] || fwd_hit[s] !== m_hit[s]) begin
          errors++;
          $display("FAIL rnd_op i=%0d s=%0d got %h/%b want %h/%b", i, s, operand[s*DW +: DW], fwd_hit[s], m_op[s], m_hit[s]);
        end
      end
      checks++;
      if (fwd !== m_fwd) begin errors++; $display("FAIL rnd_fwd i=%0d got %b want %b", i, fwd, m_fwd); end
`ifdef FWD_PERF_CNT_EN
      checks++;
      if (fwd_cnt !== CW'(m_fcnt) || stall_cnt !== CW'(m_scnt)) begin
        errors++; $display("FAIL rnd_perf i=%0d got %0d/%0d want %0d/%0d", i, fwd_cnt, stall_cnt, m_fcnt, m_scnt);
      end
`endif
    end
    rst_n = 1'b1;
    idle_inputs();
    tick(); tick();
  endtask

`ifdef FWD_PERF_CNT_EN
  task automatic test_perf();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    src_valid = 2'b11; src_reg[0] = 5'd1; src_reg[1] = 5'd2;
    stg_we = 3'b011; stg_reg[0] = 5'd1; stg_reg[1] = 5'd2;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (fwd_cnt !== 16'd6 || stall_cnt !== 16'd0) begin errors++; $display("FAIL perf_fwd got %0d/%0d want 6/0", fwd_cnt, stall_cnt); end
    src_valid = 2'b01; stg_we = 3'b001; stg_load = 3'b001;
    tick();
    stg_load = 3'b000; stg_we = 3'b000;
    tick(); tick();
    checks++;
    if (fwd_cnt !== 16'd6 || stall_cnt !== 16'd2) begin errors++; $display("FAIL perf_stall got %0d/%0d want 6/2", fwd_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    for (int s = 0; s < NS; s++) begin m_op[s] = '0; m_hit[s] = 0; end
    m_fwd = 0; m_in_stall = 0; m_left = 0; m_fcnt = 0; m_scnt = 0;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_priority();
    test_zero_reg();
    test_we_qualify();
    test_load_stall();
    test_reset_mid_stall();
    test_random();
`ifdef FWD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
